// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: state encodings,
// requester count and the rotating priority search.
package rr_arbiter_8_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // First set bit of req, searching from ptr upward and wrapping past 7 to 0.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_decoder.sv
// Gate-level 3-to-8 decoder with enable; A is the MSB of the select.
module decoder_3to8 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic en,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic y4,
    output logic y5,
    output logic y6,
    output logic y7
);

    logic a_n;
    logic b_n;
    logic c_n;

    assign a_n = ~a;
    assign b_n = ~b;
    assign c_n = ~c;

    assign y0 = en & a_n & b_n & c_n;
    assign y1 = en & a_n & b_n & c;
    assign y2 = en & a_n & b   & c_n;
    assign y3 = en & a_n & b   & c;
    assign y4 = en & a   & b_n & c_n;
    assign y5 = en & a   & b_n & c;
    assign y6 = en & a   & b   & c_n;
    assign y7 = en & a   & b   & c;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters with a bounded hold time and a
// one-cycle turnaround gap between grants.
//
//   state | meaning
//   IDLE  | arbitrate among pending requests starting at ptr
//   GRANT | resource owned by gnt_idx, hold_cnt counting
//   GAP   | turnaround cycle, all grants low; timeout pulses here
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic             hold_limit;
    logic             grant_exit;

    assign hold_limit = (hold_cnt == HOLD_LAST);
    assign grant_exit = done || !req[gnt_idx] || hold_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt_idx  <= rr_pick(req, ptr);
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (grant_exit) begin
                        state   <= GAP;
                        ptr     <= gnt_idx + 1'b1;
                        // done wins over the hold limit: completion, not a timeout
                        timeout <= hold_limit && !done;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign gnt_valid = (state == GRANT);

    decoder_3to8 u_dec (
        .a  (gnt_idx[2]),
        .b  (gnt_idx[1]),
        .c  (gnt_idx[0]),
        .en (gnt_valid),
        .y0 (gnt[0]),
        .y1 (gnt[1]),
        .y2 (gnt[2]),
        .y3 (gnt[3]),
        .y4 (gnt[4]),
        .y5 (gnt[5]),
        .y6 (gnt[6]),
        .y7 (gnt[7])
    );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: a grant-level reference model predicts each
// grant episode (owner, start cycle, length, timeout) and a monitor checks them.
module tb_rr_arbiter_8;

    localparam int HOLD_MAX = 4;
    localparam int M_ARB   = 0;
    localparam int M_OWNED = 1;
    localparam int M_TURN  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter_8 #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int idx;
        int start;
        int len;
        bit to;
    } ep_t;

    ep_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one episode per grant, in grant-cycle counts.
    int m_mode  = M_ARB;
    int m_ptr   = 0;
    int m_owner = 0;
    int m_start = 0;
    int m_held  = 0;

    task automatic model_edge(input logic [7:0] r, input logic d, input logic rs, input int e);
        ep_t ep;
        if (rs) begin
            if (m_mode == M_OWNED) begin
                ep = '{idx: m_owner, start: m_start, len: m_held + 1, to: 1'b0};
                exp_q.push_back(ep);
            end
            m_ptr  = 0;
            m_mode = M_ARB;
            return;
        end
        case (m_mode)
            M_ARB: begin
                if (r != 8'h00) begin
                    for (int k = 0; k < 8; k++) begin
                        if (r[(m_ptr + k) % 8]) begin
                            m_owner = (m_ptr + k) % 8;
                            break;
                        end
                    end
                    m_start = e;
                    m_held  = 0;
                    m_mode  = M_OWNED;
                end
            end
            M_OWNED: begin
                m_held++;
                if (d || !r[m_owner] || m_held == HOLD_MAX) begin
                    ep = '{idx: m_owner, start: m_start, len: m_held,
                           to: (m_held == HOLD_MAX) && !d};
                    exp_q.push_back(ep);
                    m_ptr  = (m_owner + 1) % 8;
                    m_mode = M_TURN;
                end
            end
            default: m_mode = M_ARB;
        endcase
    endtask

    task automatic step(input logic [7:0] r, input logic d, input logic rs);
        @(negedge clk);
        req  = r;
        done = d;
        rst  = rs;
        model_edge(r, d, rs, cyc + 1);
    endtask

    task automatic check_cleared(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_gnt"}, gnt, 8'h00);
        check({tag, "_gnt_valid"}, gnt_valid, 1'b0);
        check({tag, "_gnt_idx"}, gnt_idx, 3'd0);
        check({tag, "_timeout"}, timeout, 1'b0);
    endtask

    // Monitor: reconstruct grant episodes from the outputs and score them.
    bit mon_active = 1'b0;
    int cur_idx, cur_start, cur_len;

    initial begin
        ep_t ep;
        forever begin
            @(posedge clk);
            #1;
            check("gnt_onehot", gnt, gnt_valid ? (8'h01 << gnt_idx) : 8'h00);
            if (gnt_valid) begin
                if (!mon_active) begin
                    mon_active = 1'b1;
                    cur_idx    = gnt_idx;
                    cur_start  = cyc;
                    cur_len    = 0;
                end else begin
                    check("gnt_idx_stable", gnt_idx, cur_idx);
                end
                cur_len++;
                check("timeout_in_grant", timeout, 1'b0);
            end else if (mon_active) begin
                mon_active = 1'b0;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got idx %0d len %0d, expected none", cur_idx, cur_len);
                end else begin
                    ep = exp_q.pop_front();
                    check("grant_idx", cur_idx, ep.idx);
                    check("grant_start", cur_start, ep.start);
                    check("grant_len", cur_len, ep.len);
                    check("grant_timeout", timeout, ep.to);
                end
            end else begin
                check("timeout_idle", timeout, 1'b0);
            end
        end
    end

    initial begin
        logic [7:0] r;
        logic       d;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;

        repeat (2) step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        check_cleared("reset");

        // single requester, done on the third grant cycle
        step(8'h04, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        step(8'h04, 1'b1, 1'b0);
        repeat (3) step(8'h00, 1'b0, 1'b0);

        // fairness: everyone requesting, done every cycle
        repeat (30) step(8'hFF, 1'b1, 1'b0);

        // wrap-around: run until 6 has just been released, then only 7 and 0 request
        for (int i = 0; i < 40; i++) begin
            if (m_mode == M_TURN && m_ptr == 7) break;
            step(8'hFF, 1'b1, 1'b0);
        end
        repeat (10) step(8'h81, 1'b1, 1'b0);
        repeat (3) step(8'h00, 1'b0, 1'b0);

        // forced rotation between 5 and 6
        repeat (20) step(8'h60, 1'b0, 1'b0);
        repeat (3) step(8'h00, 1'b0, 1'b0);

        // withdrawal in the second grant cycle
        step(8'h08, 1'b0, 1'b0);
        step(8'h08, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        repeat (3) step(8'h00, 1'b0, 1'b0);

        // done coincides with the hold limit
        step(8'h10, 1'b0, 1'b0);
        repeat (HOLD_MAX - 1) step(8'h10, 1'b0, 1'b0);
        step(8'h10, 1'b1, 1'b0);
        repeat (3) step(8'h00, 1'b0, 1'b0);

        // reset in the middle of a grant to 5
        step(8'h20, 1'b0, 1'b0);
        step(8'h20, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 1'b1);
        check_cleared("reset_mid");
        repeat (8) step(8'hFF, 1'b1, 1'b0);
        repeat (3) step(8'h00, 1'b0, 1'b0);

        // random traffic with occasional resets
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) r = 8'($urandom & $urandom);
            d = ($urandom_range(4) == 0);
            step(r, d, $urandom_range(399) == 0);
        end

        repeat (12) step(8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("episodes_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
